// File: rtl/pipe_dest_if.sv
// ID-stage destination info in, per-stage destination tags out, for pipe_dest_tracker.
// Build with HAZ_STATS_EN defined to add the hazard statistics counters.
interface pipe_dest_if #(
  parameter int REG_AW = 5
);
  // ID_valid qualifies ID_RD/ID_RF_E/ID_load in the cycle it is high. There is no
  // ready: the tracker never back-pressures ID, and mem_stall freezes EX/MEM instead.
  logic [REG_AW-1:0] ID_RD;
  logic              ID_RF_E;
  logic              ID_load;
  logic              ID_valid;
  logic              bubble_in;
  logic              flush;
  logic              mem_stall;
  logic [REG_AW-1:0] RD_EX;
  logic [REG_AW-1:0] RD_MEM;
  logic [REG_AW-1:0] RD_WB;
  logic              EX_RF_E;
  logic              MEM_RF_E;
  logic              WB_RF_E;
  logic              EX_load;
  logic [1:0]        pending_writes;
  logic              flush_pending;
`ifdef HAZ_STATS_EN
  logic [15:0]       bubble_cnt;
  logic [15:0]       flush_cnt;
  logic [15:0]       stall_cnt;
`endif

  modport master (
    output ID_RD, ID_RF_E, ID_load, ID_valid, bubble_in, flush, mem_stall,
    input  RD_EX, RD_MEM, RD_WB, EX_RF_E, MEM_RF_E, WB_RF_E, EX_load,
           pending_writes, flush_pending
`ifdef HAZ_STATS_EN
    , input bubble_cnt, flush_cnt, stall_cnt
`endif
  );

  modport slave (
    input  ID_RD, ID_RF_E, ID_load, ID_valid, bubble_in, flush, mem_stall,
    output RD_EX, RD_MEM, RD_WB, EX_RF_E, MEM_RF_E, WB_RF_E, EX_load,
           pending_writes, flush_pending
`ifdef HAZ_STATS_EN
    , output bubble_cnt, flush_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/pipe_dest_tracker.sv
// Carries rd / RF write enable / load flag through EX, MEM and WB for hazard and forwarding logic.
// Optional macro HAZ_STATS_EN adds saturating bubble/flush/stall counters.
module pipe_dest_tracker #(
  parameter int REG_AW      = 5,
  parameter bit X0_SUPPRESS = 1'b1
) (
  input logic       clk,
  input logic       reset,
  pipe_dest_if.slave bus
);
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rf_e;
    logic              load;
  } stage_t;

  stage_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_stage;
  logic       flush_pending_q, flush_pending_d;
  logic [1:0] pending_writes_q, pending_writes_d;
  logic       kill;
  logic       id_rf_e_eff;

  always_comb begin
    id_rf_e_eff = bus.ID_RF_E & ~(X0_SUPPRESS & (bus.ID_RD == '0));
    id_stage    = '{rd: bus.ID_RD, rf_e: id_rf_e_eff, load: bus.ID_load};
    kill        = bus.bubble_in | bus.flush | flush_pending_q | ~bus.ID_valid;
    ex_d            = ex_q;
    mem_d           = mem_q;
    wb_d            = '0;
    flush_pending_d = 1'b0;
    // A stall freezes EX/MEM; WB drains to NOP so a finished write is forwarded once.
    if (bus.mem_stall) begin
      flush_pending_d = flush_pending_q | bus.flush;
    end else begin
      ex_d  = kill ? '0 : id_stage;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
    pending_writes_d = {1'b0, ex_d.rf_e} + {1'b0, mem_d.rf_e} + {1'b0, wb_d.rf_e};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q             <= '0;
      mem_q            <= '0;
      wb_q             <= '0;
      flush_pending_q  <= 1'b0;
      pending_writes_q <= 2'd0;
    end else begin
      ex_q             <= ex_d;
      mem_q            <= mem_d;
      wb_q             <= wb_d;
      flush_pending_q  <= flush_pending_d;
      pending_writes_q <= pending_writes_d;
    end
  end

  assign bus.RD_EX          = ex_q.rd;
  assign bus.RD_MEM         = mem_q.rd;
  assign bus.RD_WB          = wb_q.rd;
  assign bus.EX_RF_E        = ex_q.rf_e;
  assign bus.MEM_RF_E       = mem_q.rf_e;
  assign bus.WB_RF_E        = wb_q.rf_e;
  assign bus.EX_load        = ex_q.load;
  assign bus.pending_writes = pending_writes_q;
  assign bus.flush_pending  = flush_pending_q;

`ifdef HAZ_STATS_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    // A flush counts once, when it actually lands in EX (immediately or after a stall).
    if (!bus.mem_stall && bus.bubble_in && bubble_cnt_q != 16'hFFFF)
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    if (!bus.mem_stall && (bus.flush || flush_pending_q) && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
    if (bus.mem_stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= 16'd0;
      flush_cnt_q  <= 16'd0;
      stall_cnt_q  <= 16'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.stall_cnt  = stall_cnt_q;
`endif
endmodule
